kf6845_register_write_scheduler: RTL and testbench



---
 rtl/kf6845_register_write_scheduler_if.sv | 30 +++
 rtl/kf6845_register_write_scheduler.sv | 90 +++++++++
 tb/tb_kf6845_register_write_scheduler.sv | 240 ++++++++++++++++++++++++
 3 files changed

// File: rtl/kf6845_register_write_scheduler_if.sv
// Host-side and register-bus signals of the KF6845 register write scheduler.
// master drives host writes and raster timing; slave is the scheduler itself.
interface kf6845_register_write_scheduler_if;
   logic        cpu_write;
   logic        cpu_register_select;
   logic [7:0]  cpu_data_bus;
   logic        video_clock_enable;
   logic        Horizontal;
   logic        V_Display;
   logic [7:0]  internal_data_bus;
   logic [15:0] write_register_strobe;
   logic [4:0]  address_register;
   logic        fifo_full;
   logic        busy;
   logic        write_overflow;

   modport master (
      output cpu_write, cpu_register_select, cpu_data_bus,
             video_clock_enable, Horizontal, V_Display,
      input  internal_data_bus, write_register_strobe, address_register,
             fifo_full, busy, write_overflow
   );

   modport slave (
      input  cpu_write, cpu_register_select, cpu_data_bus,
             video_clock_enable, Horizontal, V_Display,
      output internal_data_bus, write_register_strobe, address_register,
             fifo_full, busy, write_overflow
   );
endinterface

// File: rtl/kf6845_register_write_scheduler.sv
// KF6845 CRTC register write scheduler: queues host data writes and replays them as strobes.
// Optional KF6845_DEFERRED_WRITE_EN holds timing registers R0..R9 until a line end in vblank.
module kf6845_register_write_scheduler #(
   parameter int FIFO_DEPTH = 4
) (
   input logic clock,
   input logic reset,
   kf6845_register_write_scheduler_if.slave bus
);
   localparam int PW = $clog2(FIFO_DEPTH);
   localparam int CW = PW + 1;

   typedef enum logic [1:0] {IDLE, ISSUE, GAP} state_t;

   state_t          state;
   logic [11:0]     mem [FIFO_DEPTH];
   logic [PW-1:0]   rd_ptr, wr_ptr;
   logic [CW-1:0]   count, count_next;
   logic [7:0]      data_q;
   logic [15:0]     strobe_q;
   logic [4:0]      addr_q;
   logic            full_q, ovf_q;
   logic [11:0]     head;
   logic            empty, full_now, go, pop, push_req, push;

   assign head     = mem[rd_ptr];
   assign empty    = (count == '0);
   assign full_now = (count == CW'(FIFO_DEPTH));

`ifdef KF6845_DEFERRED_WRITE_EN
   // Timing registers only land at the end of a line inside vertical blanking.
   assign go = (head[11:8] < 4'd10) ? (bus.Horizontal & ~bus.V_Display)
                                    : bus.video_clock_enable;
`else
   logic unused_raster;
   assign unused_raster = bus.Horizontal ^ bus.V_Display;
   assign go = bus.video_clock_enable;
`endif

   assign pop        = (state == IDLE) && !empty && go;
   assign push_req   = bus.cpu_write & bus.cpu_register_select & ~addr_q[4];
   // A pop frees a slot on the same edge, so a full queue can still accept.
   assign push       = push_req & (~full_now | pop);
   assign count_next = count + CW'(push) - CW'(pop);

   always_ff @(posedge clock) begin
      if (push) mem[wr_ptr] <= {addr_q[3:0], bus.cpu_data_bus};
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state    <= IDLE;
         rd_ptr   <= '0;
         wr_ptr   <= '0;
         count    <= '0;
         data_q   <= '0;
         strobe_q <= '0;
         addr_q   <= '0;
         full_q   <= 1'b0;
         ovf_q    <= 1'b0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         count  <= count_next;
         full_q <= (count_next == CW'(FIFO_DEPTH));
         ovf_q  <= push_req & ~push;
         if (bus.cpu_write && !bus.cpu_register_select) addr_q <= bus.cpu_data_bus[4:0];
         case (state)
            IDLE: if (pop) begin
               state    <= ISSUE;
               data_q   <= head[7:0];
               strobe_q <= 16'd1 << head[11:8];
            end
            ISSUE: begin
               state    <= GAP;
               strobe_q <= '0;
            end
            GAP:     state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.internal_data_bus     = data_q;
   assign bus.write_register_strobe = strobe_q;
   assign bus.address_register      = addr_q;
   assign bus.fifo_full             = full_q;
   assign bus.write_overflow        = ovf_q;
   assign bus.busy                  = !empty || (state != IDLE);
endmodule

// File: tb/tb_kf6845_register_write_scheduler.sv
// Directed bench for the KF6845 register write scheduler with a queue-based reference model.
// Honours KF6845_DEFERRED_WRITE_EN the same way the design does.
module tb_kf6845_register_write_scheduler;
   localparam int DEPTH = 4;

   typedef struct { int idx; int data; } ent_t;
   typedef struct { logic [15:0] s; logic [7:0] d; int c; } log_t;

   logic clock = 1'b0;
   logic reset = 1'b1;
   int   tests = 0, fails = 0;
   bit   chk_en = 1'b0;
   int   vce_mode = 0;
   int   cyc = 0;
   int   ovf_seen = 0;
   log_t slog[$];

   kf6845_register_write_scheduler_if bus ();

   kf6845_register_write_scheduler #(.FIFO_DEPTH(DEPTH)) dut (
      .clock(clock), .reset(reset), .bus(bus.slave)
   );

   always #5 clock = ~clock;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Reference model: a plain queue plus a cooldown of two edges after each issue.
   ent_t        q[$];
   int          cool = 0;
   logic [7:0]  e_data = 0;
   logic [15:0] e_strobe = 0;
   int          e_addr = 0;
   bit          e_full = 0, e_busy = 0, e_ovf = 0;

   initial forever begin
      bit issue;
      @(posedge clock);
      if (reset) begin
         q.delete();
         cool = 0; e_data = 0; e_strobe = 0; e_addr = 0;
         e_full = 0; e_busy = 0; e_ovf = 0;
      end else begin
         issue = 0;
         if (cool == 0 && q.size() > 0) begin
`ifdef KF6845_DEFERRED_WRITE_EN
            issue = (q[0].idx < 10) ? (bus.Horizontal && !bus.V_Display) : bus.video_clock_enable;
`else
            issue = bus.video_clock_enable;
`endif
         end
         if (cool > 0) cool--;
         e_strobe = 0;
         if (issue) begin
            e_strobe = 16'h1 << q[0].idx;
            e_data   = 8'(q[0].data);
            void'(q.pop_front());
            cool = 2;
         end
         e_ovf = 0;
         if (bus.cpu_write && bus.cpu_register_select && e_addr < 16) begin
            if (q.size() < DEPTH) q.push_back('{e_addr, int'(bus.cpu_data_bus)});
            else e_ovf = 1;
         end
         if (bus.cpu_write && !bus.cpu_register_select) e_addr = int'(bus.cpu_data_bus[4:0]);
         e_full = (q.size() == DEPTH);
         e_busy = (q.size() > 0) || (cool > 0);
      end
   end

   always @(negedge clock) begin
      if (chk_en) begin
         chk("cyc_data",     32'(bus.internal_data_bus),     32'(e_data));
         chk("cyc_strobe",   32'(bus.write_register_strobe), 32'(e_strobe));
         chk("cyc_addr",     32'(bus.address_register),      32'(e_addr));
         chk("cyc_full",     32'(bus.fifo_full),             32'(e_full));
         chk("cyc_busy",     32'(bus.busy),                  32'(e_busy));
         chk("cyc_overflow", 32'(bus.write_overflow),        32'(e_ovf));
      end
   end

   // Strobe logger, sampled just after each active edge.
   initial forever begin
      @(posedge clock);
      #1;
      cyc++;
      if (bus.write_register_strobe != 0)
         slog.push_back('{bus.write_register_strobe, bus.internal_data_bus, cyc});
      if (bus.write_overflow) ovf_seen++;
   end

   task automatic step();
      @(negedge clock);
      case (vce_mode)
         0:       bus.video_clock_enable = 1'b0;
         1:       bus.video_clock_enable = ~bus.video_clock_enable;
         default: bus.video_clock_enable = 1'b1;
      endcase
   endtask

   task automatic steps(input int n);
      repeat (n) step();
   endtask

   task automatic wr(input logic rs, input logic [7:0] d);
      step();
      bus.cpu_write = 1'b1;
      bus.cpu_register_select = rs;
      bus.cpu_data_bus = d;
      step();
      bus.cpu_write = 1'b0;
   endtask

   initial begin
      int t0;
      bus.cpu_write = 0; bus.cpu_register_select = 0; bus.cpu_data_bus = 0;
      bus.video_clock_enable = 0; bus.Horizontal = 0; bus.V_Display = 0;
      reset = 1'b1;
      steps(3);
      chk("rst_data",   32'(bus.internal_data_bus),     0);
      chk("rst_strobe", 32'(bus.write_register_strobe), 0);
      chk("rst_addr",   32'(bus.address_register),      0);
      chk("rst_full",   32'(bus.fifo_full),             0);
      chk("rst_busy",   32'(bus.busy),                  0);
      chk("rst_ovf",    32'(bus.write_overflow),        0);
      chk_en = 1'b1;
      reset = 1'b0;

      // Immediate write of R4 = 30 with vce every other cycle.
      vce_mode = 1;
      slog.delete();
      wr(0, 8'd4);
      wr(1, 8'd30);
      t0 = cyc;
      steps(10);
      chk("imm_count",  32'(slog.size()), 1);
      if (slog.size() > 0) begin
         chk("imm_strobe",  32'(slog[0].s), 32'h0010);
         chk("imm_data",    32'(slog[0].d), 30);
         chk("imm_latency", 32'(slog[0].c - t0 <= 3), 1);
      end
      chk("imm_busy", 32'(bus.busy), 0);

      // Burst of five into a depth-four queue with no go condition.
      vce_mode = 0;
      slog.delete();
      wr(0, 8'd12);
      for (int i = 1; i <= 5; i++) begin
         wr(1, 8'(i));
         if (i == 3) chk("burst_notfull", 32'(bus.fifo_full), 0);
         if (i == 4) chk("burst_full",    32'(bus.fifo_full), 1);
         if (i == 5) chk("burst_ovf",     32'(bus.write_overflow), 1);
      end
      chk("burst_nostrobe", 32'(slog.size()), 0);
      vce_mode = 2;
      steps(20);
      chk("drain_count", 32'(slog.size()), 4);
      for (int k = 0; k < slog.size() && k < 4; k++) begin
         chk("drain_strobe", 32'(slog[k].s), 32'h1000);
         chk("drain_data",   32'(slog[k].d), 32'(k + 1));
         if (k > 0) chk("drain_gap", 32'(slog[k].c - slog[k-1].c >= 3), 1);
      end
      chk("ovf_total", 32'(ovf_seen), 1);
      chk("drain_busy", 32'(bus.busy), 0);

      // Light-pen / invalid index is discarded silently.
      slog.delete();
      wr(0, 8'd17);
      wr(1, 8'hAA);
      steps(5);
      chk("inv_nostrobe", 32'(slog.size()), 0);
      chk("inv_busy",     32'(bus.busy), 0);
      chk("inv_addr",     32'(bus.address_register), 17);
      chk("inv_ovf",      32'(ovf_seen), 1);

      // R6 during active display, followed by R14.
      bus.V_Display = 1'b1;
      slog.delete();
      wr(0, 8'd6);
      wr(1, 8'd20);
      t0 = cyc;
      wr(0, 8'd14);
      wr(1, 8'd7);
      steps(8);
`ifdef KF6845_DEFERRED_WRITE_EN
      chk("def_blocked", 32'(slog.size()), 0);
      chk("def_busy",    32'(bus.busy), 1);
      step(); bus.Horizontal = 1'b1;
      step(); bus.Horizontal = 1'b0;
      steps(3);
      chk("def_hblank_vdisp", 32'(slog.size()), 0);
      bus.V_Display = 1'b0;
      step(); bus.Horizontal = 1'b1;
      step(); bus.Horizontal = 1'b0;
      steps(8);
`else
      if (slog.size() > 0) chk("def_latency", 32'(slog[0].c - t0 <= 3), 1);
`endif
      chk("def_count", 32'(slog.size()), 2);
      if (slog.size() == 2) begin
         chk("def_first_strobe",  32'(slog[0].s), 32'h0040);
         chk("def_first_data",    32'(slog[0].d), 20);
         chk("def_second_strobe", 32'(slog[1].s), 32'h4000);
         chk("def_second_data",   32'(slog[1].d), 7);
      end
      bus.V_Display = 1'b0;
      bus.Horizontal = 1'b0;

      // Reset with three entries queued and a strobe in flight.
      vce_mode = 0;
      wr(0, 8'd12);
      for (int i = 0; i < 4; i++) wr(1, 8'(8'h41 + i));
      vce_mode = 2;
      step();
      vce_mode = 0;
      step();
      chk("mid_strobe", 32'(bus.write_register_strobe), 32'h1000);
      chk("mid_data",   32'(bus.internal_data_bus), 32'h41);
      reset = 1'b1;
      step();
      chk("rst2_strobe", 32'(bus.write_register_strobe), 0);
      chk("rst2_busy",   32'(bus.busy), 0);
      chk("rst2_addr",   32'(bus.address_register), 0);
      chk("rst2_full",   32'(bus.fifo_full), 0);
      reset = 1'b0;
      slog.delete();
      vce_mode = 2;
      steps(10);
      chk("rst2_nostrobe", 32'(slog.size()), 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
